// File: rtl/mollusc_mem_pkg.sv
// Shared types and widths for the core's memory-port arbitration logic.
package mollusc_mem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BE_W     = XLEN / 8;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-outstanding req/gnt/rvalid memory bus between the arbiter and memory.
interface mem_port_arbiter_if;
  import mollusc_mem_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data first, fetch forced once starvation limit is hit.
module mem_arb_pick
  import mollusc_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                pick_valid_c,
  output owner_e              pick_owner_c
);

  always_comb begin
    pick_valid_c = if_req | d_req;
    pick_owner_c = OWN_I;
    if (d_req && !(if_req && (starve_cnt >= STARVE_W'(STARVE_LIMIT)))) begin
      pick_owner_c = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit,
// one transaction at a time, with kill-squashing of stale fetch responses.
module mem_port_arbiter
  import mollusc_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_stall,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_done,
  output logic [XLEN-1:0] d_rdata,
  mem_port_arbiter_if.master mem
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                discard_q, discard_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_done_q, d_done_d;
  logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]     d_rdata_q, d_rdata_d;

  logic   pick_valid_c;
  owner_e pick_owner_c;
  logic   kill_hit_c;
  logic   rsp_take_c;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .if_req       (if_req),
    .d_req        (d_req),
    .starve_cnt   (starve_q),
    .pick_valid_c (pick_valid_c),
    .pick_owner_c (pick_owner_c)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    kill_hit_c  = if_kill && (owner_q == OWN_I);
    rsp_take_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (pick_valid_c) begin
          owner_d   = pick_owner_c;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
          if (pick_owner_c == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q < STARVE_W'(STARVE_LIMIT)) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = {BE_W{1'b1}};
            starve_d    = '0;
          end
        end
      end
      S_ISSUE: begin
        if (kill_hit_c) discard_d = 1'b1;
        if (mem.mem_gnt) begin
          mem_req_d  = 1'b0;
          rsp_take_c = mem.mem_rvalid;
          state_d    = mem.mem_rvalid ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (kill_hit_c) discard_d = 1'b1;
        if (mem.mem_rvalid) begin
          rsp_take_c = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A kill arriving on the response cycle itself must also squash the pulse.
    if (rsp_take_c) begin
      if (owner_q == OWN_D) begin
        d_rdata_d = mem.mem_rdata;
        d_done_d  = 1'b1;
      end else begin
        if_rdata_d  = mem.mem_rdata;
        if_rvalid_d = !(discard_q || kill_hit_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_stall      = if_req & ~if_rvalid_q;
  assign if_rvalid     = if_rvalid_q;
  assign if_rdata      = if_rdata_q;
  assign d_done        = d_done_q;
  assign d_rdata       = d_rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule
